// File: rtl/led_seq_controller_if.sv
// led_seq_controller_if: control inputs and LED/status outputs of the LED sequencer
interface led_seq_controller_if;
  logic        start;
  logic        stop;
  logic        pause;
  logic        speed;
  logic        step2;
  logic        invert;
  logic [3:0]  start_pos;
  logic [3:0]  laps;
  logic [15:0] led;
  logic [3:0]  position;
  logic        busy;
  logic        lap_done;
  logic        seq_done;
  modport master (
    output start, stop, pause, speed, step2, invert, start_pos, laps,
    input  led, position, busy, lap_done, seq_done
  );
  modport slave (
    input  start, stop, pause, speed, step2, invert, start_pos, laps,
    output led, position, busy, lap_done, seq_done
  );
endinterface

// File: rtl/led_seq_controller.sv
// led_seq_controller: chasing-LED sequencer with pause, speed select, double step and lap counting
module led_seq_controller #(
  parameter int DIV_SLOW = 100_000_000,
  parameter int DIV_FAST = 50_000_000
) (
  input logic clk,
  input logic rst_n,
  led_seq_controller_if.slave bus
);
  localparam int DMAX = DIV_SLOW > DIV_FAST ? DIV_SLOW : DIV_FAST;
  localparam int CW = $clog2(DMAX + 1);
  localparam logic [CW-1:0] SLOW_M1 = CW'(DIV_SLOW - 1);
  localparam logic [CW-1:0] FAST_M1 = CW'(DIV_FAST - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_lap;
  logic [3:0]    r_start_pos;
  logic [3:0]    r_laps;
  logic          r_step2;
  logic          r_invert;
  logic [15:0]   r_led;
  logic [3:0]    r_pos;
  logic          r_busy;
  logic          r_lap_done;
  logic          r_seq_done;
  logic [CW-1:0] w_div_m1;
  logic          w_tick;
  logic [3:0]    w_next;
  logic          w_wrap;
  logic          w_last;
  logic [15:0]   w_home;
  logic [15:0]   w_start_pat;
  // >= rather than == so a slow-to-fast switch mid-count ticks immediately
  assign w_div_m1    = bus.speed ? FAST_M1 : SLOW_M1;
  assign w_tick      = r_cnt >= w_div_m1;
  assign w_next      = r_pos + (r_step2 ? 4'd2 : 4'd1);
  assign w_wrap      = w_next == r_start_pos;
  assign w_last      = (r_laps != 4'd0) && (r_lap + 4'd1 == r_laps);
  assign w_home      = {16{r_invert}} ^ (16'd1 << r_start_pos);
  assign w_start_pat = {16{bus.invert}} ^ (16'd1 << bus.start_pos);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_lap       <= '0;
      r_start_pos <= '0;
      r_laps      <= '0;
      r_step2     <= 1'b0;
      r_invert    <= 1'b0;
      r_led       <= '0;
      r_pos       <= '0;
      r_busy      <= 1'b0;
      r_lap_done  <= 1'b0;
      r_seq_done  <= 1'b0;
    end else begin
      r_lap_done <= 1'b0;
      r_seq_done <= 1'b0;
      if (bus.stop) begin
        r_state <= IDLE;
        r_led   <= {16{bus.invert}};
        r_pos   <= bus.start_pos;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE, DONE: begin
            if (bus.start) begin
              r_state     <= RUN;
              r_start_pos <= bus.start_pos;
              r_laps      <= bus.laps;
              r_step2     <= bus.step2;
              r_invert    <= bus.invert;
              r_led       <= w_start_pat;
              r_pos       <= bus.start_pos;
              r_cnt       <= '0;
              r_lap       <= '0;
              r_busy      <= 1'b1;
            end else if (r_state == IDLE) begin
              r_led <= {16{bus.invert}};
              r_pos <= bus.start_pos;
            end
          end
          RUN: begin
            if (bus.pause) begin
              r_state <= PAUSED;
            end else if (w_tick) begin
              r_cnt <= '0;
              if (!w_wrap) begin
                r_led[w_next] <= ~r_invert;
                r_pos         <= w_next;
              end else begin
                r_lap_done <= 1'b1;
                r_lap      <= r_lap + 4'd1;
                if (w_last) begin
                  r_state    <= DONE;
                  r_seq_done <= 1'b1;
                  r_busy     <= 1'b0;
                end else begin
                  r_led <= w_home;
                  r_pos <= r_start_pos;
                end
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          PAUSED: r_state <= bus.pause ? PAUSED : RUN;
          default: r_state <= IDLE;
        endcase
      end
    end
  end
  assign bus.led      = r_led;
  assign bus.position = r_pos;
  assign bus.busy     = r_busy;
  assign bus.lap_done = r_lap_done;
  assign bus.seq_done = r_seq_done;
endmodule

// File: tb/tb_led_seq_controller.sv
// tb_led_seq_controller: table-driven vectors plus continuous-mode sequence, checked through a scoreboard queue
module tb_led_seq_controller;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  led_seq_controller_if bus();
  led_seq_controller #(.DIV_SLOW(4), .DIV_FAST(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    string       name;
    logic [15:0] led;
    logic [3:0]  pos;
    logic        busy, ld, sd;
  } exp_t;
  typedef struct {
    logic        rst_n, start, stop, pause, speed, step2, invert;
    logic [3:0]  sp, laps;
    int          cyc;
    logic [15:0] led;
    logic [3:0]  pos;
    logic        busy, ld, sd;
  } vec_t;
  exp_t sb[$];
  vec_t vt[$];
  int n_cmp = 0;
  int n_bad = 0;
  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: empty queue at check");
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if ({bus.led, bus.position, bus.busy, bus.lap_done, bus.seq_done} !== {e.led, e.pos, e.busy, e.ld, e.sd}) begin
      n_bad++;
      $display("FAIL %s: got led=%h pos=%0d busy=%b lap=%b seq=%b, want led=%h pos=%0d busy=%b lap=%b seq=%b",
               e.name, bus.led, bus.position, bus.busy, bus.lap_done, bus.seq_done,
               e.led, e.pos, e.busy, e.ld, e.sd);
    end
  endtask
  task automatic drive(input vec_t v);
    rst_n         = v.rst_n;
    bus.start     = v.start;
    bus.stop      = v.stop;
    bus.pause     = v.pause;
    bus.speed     = v.speed;
    bus.step2     = v.step2;
    bus.invert    = v.invert;
    bus.start_pos = v.sp;
    bus.laps      = v.laps;
  endtask
  initial begin
    // rst_n start stop pause speed step2 invert sp laps cyc | led pos busy lap seq
    vt.push_back(vec_t'{0,0,0,0,0,0,1, 5,0, 1, 16'h0000, 0,0,0,0});
    vt.push_back(vec_t'{1,0,0,0,0,0,1, 5,0, 1, 16'hFFFF, 5,0,0,0});
    vt.push_back(vec_t'{1,0,0,0,0,0,0, 3,0, 1, 16'h0000, 3,0,0,0});
    vt.push_back(vec_t'{1,1,0,0,0,0,0, 3,1, 1, 16'h0008, 3,1,0,0});
    vt.push_back(vec_t'{1,0,0,0,0,0,0, 3,1, 4, 16'h0018, 4,1,0,0});
    vt.push_back(vec_t'{1,0,0,0,0,0,0, 3,1, 4, 16'h0038, 5,1,0,0});
    vt.push_back(vec_t'{1,0,0,0,0,0,1, 9,1, 4, 16'h0078, 6,1,0,0});
    vt.push_back(vec_t'{1,1,0,0,0,0,1, 9,1, 4, 16'h00F8, 7,1,0,0});
    vt.push_back(vec_t'{1,0,0,0,0,0,1, 9,1,47, 16'hFFFF, 2,1,0,0});
    vt.push_back(vec_t'{1,0,0,0,0,0,1, 9,1, 1, 16'hFFFF, 2,0,1,1});
    vt.push_back(vec_t'{1,0,0,0,0,0,1, 9,1, 1, 16'hFFFF, 2,0,0,0});
    vt.push_back(vec_t'{1,1,1,0,0,0,0, 9,1, 1, 16'h0000, 9,0,0,0});
    vt.push_back(vec_t'{1,0,0,0,0,0,1, 4,0, 1, 16'hFFFF, 4,0,0,0});
    vt.push_back(vec_t'{1,1,0,0,1,1,1,14,2, 1, 16'hBFFF,14,1,0,0});
    vt.push_back(vec_t'{1,0,0,0,1,1,1,14,2, 2, 16'hBFFE, 0,1,0,0});
    vt.push_back(vec_t'{1,0,0,0,1,1,1,14,2,13, 16'hAAAA,12,1,0,0});
    vt.push_back(vec_t'{1,0,0,0,1,1,1,14,2, 1, 16'hBFFF,14,1,1,0});
    vt.push_back(vec_t'{1,0,0,0,1,1,1,14,2,15, 16'hAAAA,12,1,0,0});
    vt.push_back(vec_t'{1,0,0,0,1,1,1,14,2, 1, 16'hAAAA,12,0,1,1});
    vt.push_back(vec_t'{1,1,0,0,0,0,0, 0,0, 1, 16'h0001, 0,1,0,0});
    vt.push_back(vec_t'{1,0,0,0,0,0,0, 0,0, 2, 16'h0001, 0,1,0,0});
    vt.push_back(vec_t'{1,0,0,0,1,0,0, 0,0, 1, 16'h0003, 1,1,0,0});
    vt.push_back(vec_t'{1,0,0,0,1,0,0, 0,0, 2, 16'h0007, 2,1,0,0});
    vt.push_back(vec_t'{1,0,0,0,1,0,0, 0,0, 6, 16'h003F, 5,1,0,0});
    vt.push_back(vec_t'{1,0,0,0,1,0,0, 0,0, 1, 16'h003F, 5,1,0,0});
    vt.push_back(vec_t'{1,0,0,1,1,0,0, 0,0,10, 16'h003F, 5,1,0,0});
    vt.push_back(vec_t'{1,0,0,0,1,0,0, 0,0, 1, 16'h003F, 5,1,0,0});
    vt.push_back(vec_t'{1,0,0,0,1,0,0, 0,0, 1, 16'h007F, 6,1,0,0});
    vt.push_back(vec_t'{0,0,0,0,1,0,0, 0,0, 1, 16'h0000, 0,0,0,0});
    vt.push_back(vec_t'{1,0,0,0,1,0,1, 7,0, 1, 16'hFFFF, 7,0,0,0});
    vt.push_back(vec_t'{1,1,0,0,1,1,0, 0,1, 1, 16'h0001, 0,1,0,0});
    vt.push_back(vec_t'{1,0,0,0,1,1,0, 0,1,15, 16'h5555,14,1,0,0});
    vt.push_back(vec_t'{1,0,1,0,1,1,0, 0,1, 1, 16'h0000, 0,0,0,0});
    vt.push_back(vec_t'{1,1,0,0,0,0,0, 8,0, 1, 16'h0100, 8,1,0,0});
    vt.push_back(vec_t'{1,0,0,0,0,0,0, 8,0, 3, 16'h0100, 8,1,0,0});
    vt.push_back(vec_t'{1,0,0,1,0,0,0, 8,0, 1, 16'h0100, 8,1,0,0});
    vt.push_back(vec_t'{1,0,0,0,0,0,0, 8,0, 1, 16'h0100, 8,1,0,0});
    vt.push_back(vec_t'{1,0,0,0,0,0,0, 8,0, 1, 16'h0300, 9,1,0,0});
    foreach (vt[i]) begin
      drive(vt[i]);
      sb.push_back(exp_t'{$sformatf("vec%0d", i), vt[i].led, vt[i].pos, vt[i].busy, vt[i].ld, vt[i].sd});
      repeat (vt[i].cyc) @(negedge clk);
      check_out();
    end
    // continuous laps at fast speed, single step, from LED 0
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0; bus.start = 1'b1; bus.pause = 1'b0; bus.speed = 1'b1;
    bus.step2 = 1'b0; bus.invert = 1'b0; bus.start_pos = 4'd0; bus.laps = 4'd0;
    sb.push_back(exp_t'{"cont_accept", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    check_out();
    bus.start = 1'b0;
    for (int i = 1; i <= 96; i++) begin
      int p;
      logic [31:0] m;
      p = (i / 2) % 16;
      m = (32'd1 << (p + 1)) - 32'd1;
      sb.push_back(exp_t'{$sformatf("cont%0d", i), m[15:0], 4'(p), 1'b1, (i % 32) == 0, 1'b0});
      @(negedge clk);
      check_out();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
